// File: rtl/ahb_uart_bridge.sv
// ahb_uart_bridge: turns 'W'/'R' command bytes from a UART RX stream into
// single AHB-Lite word transfers and returns 'K', 'E', '?' or read data
// bytes on a UART TX stream.
module ahb_uart_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_AHB_ADDR,
        S_AHB_DATA,
        S_RESP
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic        wr, wr_n;
    logic [31:0] addr, addr_n;
    logic [31:0] wdata, wdata_n;
    logic [31:0] tx_buf, tx_buf_n;
    logic [1:0]  tx_cnt, tx_cnt_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [31:0] timer, timer_n;
    logic        err, err_n;
    logic        rx_fire, tx_fire, err_hit;

    assign rx_ready = (state == S_IDLE) || (state == S_GET_ADDR) || (state == S_GET_DATA);
    assign tx_valid = (state == S_RESP);
    assign tx_data  = tx_valid ? tx_buf[31:24] : 8'h00;
    assign rx_fire  = rx_valid & rx_ready;
    assign tx_fire  = tx_valid & tx_ready;
    assign busy     = (state != S_IDLE);

    assign HTRANS = (state == S_AHB_ADDR) ? 2'b10 : 2'b00;
    assign HWRITE = (state == S_AHB_ADDR) ? wr : 1'b0;
    assign HADDR  = {addr[31:2], 2'b00};
    assign HWDATA = wdata;
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;
    assign HPROT  = 4'b0011;

    // State register and datapath registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            wr       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            tx_buf   <= '0;
            tx_cnt   <= '0;
            byte_cnt <= '0;
            timer    <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            wr       <= wr_n;
            addr     <= addr_n;
            wdata    <= wdata_n;
            tx_buf   <= tx_buf_n;
            tx_cnt   <= tx_cnt_n;
            byte_cnt <= byte_cnt_n;
            timer    <= timer_n;
            err      <= err_n;
        end
    end

    // Next-state and next-datapath logic for the command/bus/response sequence
    always_comb begin
        state_n    = state;
        wr_n       = wr;
        addr_n     = addr;
        wdata_n    = wdata;
        tx_buf_n   = tx_buf;
        tx_cnt_n   = tx_cnt;
        byte_cnt_n = byte_cnt;
        timer_n    = timer;
        err_n      = err;
        err_hit    = err | HRESP;

        case (state)
            S_IDLE: begin
                timer_n = '0;
                if (rx_fire) begin
                    byte_cnt_n = '0;
                    if (rx_data == 8'h57) begin
                        wr_n    = 1'b1;
                        state_n = S_GET_ADDR;
                    end else if (rx_data == 8'h52) begin
                        wr_n    = 1'b0;
                        state_n = S_GET_ADDR;
                    end else begin
                        tx_buf_n = {8'h3F, 24'h000000};
                        tx_cnt_n = '0;
                        state_n  = S_RESP;
                    end
                end
            end

            S_GET_ADDR: begin
                if (rx_fire) begin
                    addr_n     = {addr[23:0], rx_data};
                    byte_cnt_n = byte_cnt + 2'd1;
                    timer_n    = '0;
                    if (byte_cnt == 2'd3)
                        state_n = wr ? S_GET_DATA : S_AHB_ADDR;
                end else if (timer == TMO_LAST) begin
                    timer_n = '0;
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer + 32'd1;
                end
            end

            S_GET_DATA: begin
                if (rx_fire) begin
                    wdata_n    = {wdata[23:0], rx_data};
                    byte_cnt_n = byte_cnt + 2'd1;
                    timer_n    = '0;
                    if (byte_cnt == 2'd3)
                        state_n = S_AHB_ADDR;
                end else if (timer == TMO_LAST) begin
                    timer_n = '0;
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer + 32'd1;
                end
            end

            S_AHB_ADDR: begin
                if (HREADY)
                    state_n = S_AHB_DATA;
            end

            S_AHB_DATA: begin
                err_n = err_hit;
                if (HREADY) begin
                    state_n = S_RESP;
                    if (err_hit) begin
                        tx_buf_n = {8'h45, 24'h000000};
                        tx_cnt_n = '0;
                    end else if (wr) begin
                        tx_buf_n = {8'h4B, 24'h000000};
                        tx_cnt_n = '0;
                    end else begin
                        tx_buf_n = HRDATA;
                        tx_cnt_n = 2'd3;
                    end
                end
            end

            S_RESP: begin
                if (tx_fire) begin
                    if (tx_cnt == 2'd0) begin
                        err_n   = 1'b0;
                        state_n = S_IDLE;
                    end else begin
                        tx_buf_n = {tx_buf[23:0], 8'h00};
                        tx_cnt_n = tx_cnt - 2'd1;
                    end
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ahb_uart_bridge.sv
// tb_ahb_uart_bridge: directed scenarios for the UART-to-AHB command bridge.
module tb_ahb_uart_bridge;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        busy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    ahb_uart_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .busy(busy)
    );

    // 100 MHz-style free-running clock
    always #5 HCLK = ~HCLK;

    // Hard time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    // Present one byte and return at the negedge after it was consumed
    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge HCLK);
            n++;
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_byte_%h: rx_ready=%b, expected 1", b, rx_ready);
        end
        @(negedge HCLK);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        @(negedge HCLK);
        checks++; if (rx_ready !== 1'b1)   begin errors++; $display("FAIL reset_rx_ready: got %b expected 1", rx_ready); end
        checks++; if (tx_valid !== 1'b0)   begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00)   begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (HTRANS !== 2'b00)    begin errors++; $display("FAIL reset_htrans: got %b expected 00", HTRANS); end
        checks++; if (HWRITE !== 1'b0)     begin errors++; $display("FAIL reset_hwrite: got %b expected 0", HWRITE); end
        checks++; if (HADDR !== 32'h0)     begin errors++; $display("FAIL reset_haddr: got %h expected 0", HADDR); end
        checks++; if (HWDATA !== 32'h0)    begin errors++; $display("FAIL reset_hwdata: got %h expected 0", HWDATA); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (HSIZE !== 3'b010)    begin errors++; $display("FAIL hsize: got %b expected 010", HSIZE); end
        checks++; if (HBURST !== 3'b000)   begin errors++; $display("FAIL hburst: got %b expected 000", HBURST); end
        checks++; if (HPROT !== 4'b0011)   begin errors++; $display("FAIL hprot: got %b expected 0011", HPROT); end
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    task automatic test_write();
        logic [7:0] cmd [9];
        cmd = '{8'h57, 8'h20, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        tx_ready = 1'b1; HREADY = 1'b1;
        foreach (cmd[i]) send_byte(cmd[i]);
        checks++; if (HTRANS !== 2'b10)       begin errors++; $display("FAIL wr_htrans: got %b expected 10", HTRANS); end
        checks++; if (HADDR !== 32'h20000004) begin errors++; $display("FAIL wr_haddr: got %h expected 20000004", HADDR); end
        checks++; if (HWRITE !== 1'b1)        begin errors++; $display("FAIL wr_hwrite: got %b expected 1", HWRITE); end
        checks++; if (rx_ready !== 1'b0)      begin errors++; $display("FAIL wr_rx_ready: got %b expected 0", rx_ready); end
        @(negedge HCLK);
        checks++; if (HTRANS !== 2'b00)       begin errors++; $display("FAIL wr_data_htrans: got %b expected 00", HTRANS); end
        checks++; if (HWDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_hwdata: got %h expected deadbeef", HWDATA); end
        @(negedge HCLK);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin errors++; $display("FAIL wr_resp: got v=%b d=%h expected v=1 d=4b", tx_valid, tx_data); end
        @(negedge HCLK);
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL wr_done: got busy=%b tx_valid=%b expected 0 0", busy, tx_valid); end
    endtask

    task automatic test_read_wait();
        logic [7:0]  cmd [5];
        logic [31:0] exp = 32'h12345678;
        cmd = '{8'h52, 8'h00, 8'h00, 8'h01, 8'h03};
        tx_ready = 1'b1; HREADY = 1'b1;
        foreach (cmd[i]) send_byte(cmd[i]);
        checks++; if (HTRANS !== 2'b10)       begin errors++; $display("FAIL rd_htrans: got %b expected 10", HTRANS); end
        checks++; if (HADDR !== 32'h00000100) begin errors++; $display("FAIL rd_haddr: got %h expected 00000100", HADDR); end
        checks++; if (HWRITE !== 1'b0)        begin errors++; $display("FAIL rd_hwrite: got %b expected 0", HWRITE); end
        @(negedge HCLK);
        HREADY = 1'b0;
        checks++; if (HTRANS !== 2'b00)       begin errors++; $display("FAIL rd_data_htrans: got %b expected 00", HTRANS); end
        repeat (3) @(negedge HCLK);
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rd_wait: got tx_valid=%b busy=%b expected 0 1", tx_valid, busy); end
        HREADY = 1'b1; HRDATA = 32'h12345678;
        @(negedge HCLK);
        HRDATA = 32'h0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp[31-8*i -: 8]) begin
                errors++;
                $display("FAIL rd_byte%0d: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, exp[31-8*i -: 8]);
            end
            @(negedge HCLK);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_done: got busy=%b expected 0", busy); end
    endtask

    task automatic test_error();
        logic [7:0] cmd [9];
        cmd = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        tx_ready = 1'b1; HREADY = 1'b1;
        foreach (cmd[i]) send_byte(cmd[i]);
        checks++; if (HADDR !== 32'h40000000 || HTRANS !== 2'b10) begin errors++; $display("FAIL err_addr: got %h/%b expected 40000000/10", HADDR, HTRANS); end
        @(negedge HCLK);
        HRESP = 1'b1; HREADY = 1'b0;
        @(negedge HCLK);
        HREADY = 1'b1;
        @(negedge HCLK);
        HRESP = 1'b0;
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h45) begin errors++; $display("FAIL err_resp: got v=%b d=%h expected v=1 d=45", tx_valid, tx_data); end
        @(negedge HCLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_unknown_and_stall();
        logic [7:0]  cmd [5];
        logic [31:0] exp = 32'hA5C30F96;
        tx_ready = 1'b1; HREADY = 1'b1;
        send_byte(8'h41);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h3F) begin errors++; $display("FAIL unk_resp: got v=%b d=%h expected v=1 d=3f", tx_valid, tx_data); end
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL unk_htrans: got %b expected 00", HTRANS); end
        @(negedge HCLK);
        checks++; if (busy !== 1'b0 || HTRANS !== 2'b00) begin errors++; $display("FAIL unk_idle: got busy=%b htrans=%b expected 0 00", busy, HTRANS); end
        tx_ready = 1'b0;
        cmd = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h10};
        foreach (cmd[i]) send_byte(cmd[i]);
        HRDATA = exp;
        @(negedge HCLK);
        @(negedge HCLK);
        HRDATA = 32'h0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || rx_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: got v=%b d=%h rx_ready=%b expected v=1 d=a5 rx_ready=0", i, tx_valid, tx_data, rx_ready);
            end
            @(negedge HCLK);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp[31-8*i -: 8]) begin
                errors++;
                $display("FAIL stall_byte%0d: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, exp[31-8*i -: 8]);
            end
            @(negedge HCLK);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_done: got busy=%b expected 0", busy); end
    endtask

    task automatic test_timeout();
        logic [7:0] cmd [9];
        tx_ready = 1'b1; HREADY = 1'b1;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (15) @(negedge HCLK);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_before: got busy=%b expected 1", busy); end
        @(negedge HCLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_expired: got busy=%b expected 0", busy); end
        cmd = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44};
        foreach (cmd[i]) send_byte(cmd[i]);
        checks++; if (HADDR !== 32'h00000008 || HWRITE !== 1'b1 || HTRANS !== 2'b10) begin errors++; $display("FAIL tmo_next_addr: got %h/%b/%b expected 00000008/1/10", HADDR, HWRITE, HTRANS); end
        @(negedge HCLK);
        checks++; if (HWDATA !== 32'h11223344) begin errors++; $display("FAIL tmo_next_hwdata: got %h expected 11223344", HWDATA); end
        @(negedge HCLK);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin errors++; $display("FAIL tmo_next_resp: got v=%b d=%h expected v=1 d=4b", tx_valid, tx_data); end
        @(negedge HCLK);
    endtask

    task automatic test_reset_mid();
        logic [7:0]  cmd [5];
        logic [31:0] exp = 32'hCAFEF00D;
        cmd = '{8'h52, 8'h00, 8'h00, 8'h02, 8'h00};
        tx_ready = 1'b1; HREADY = 1'b1;
        foreach (cmd[i]) send_byte(cmd[i]);
        @(negedge HCLK);
        HREADY = 1'b0;
        @(negedge HCLK);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
        #2 HRESETn = 1'b0;
        #1;
        checks++; if (HTRANS !== 2'b00 || tx_valid !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: got htrans=%b tx_valid=%b busy=%b rx_ready=%b expected 00 0 0 1", HTRANS, tx_valid, busy, rx_ready);
        end
        @(negedge HCLK);
        HRESETn = 1'b1; HREADY = 1'b1;
        foreach (cmd[i]) send_byte(cmd[i]);
        checks++; if (HADDR !== 32'h00000200 || HTRANS !== 2'b10) begin errors++; $display("FAIL rst_after_addr: got %h/%b expected 00000200/10", HADDR, HTRANS); end
        HRDATA = exp;
        @(negedge HCLK);
        @(negedge HCLK);
        HRDATA = 32'h0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp[31-8*i -: 8]) begin
                errors++;
                $display("FAIL rst_after_byte%0d: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, exp[31-8*i -: 8]);
            end
            @(negedge HCLK);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_after_done: got busy=%b expected 0", busy); end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_error();
        test_unknown_and_stall();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
